riscv_core_div_ctrl: RTL

Sequencing controller for the M-extension integer divider: DIV, DIVU, REM, REMU and the W forms.
- Accepts one request at a time on a valid/ready handshake.
- Conditions operands to magnitudes, runs a one-bit-per-cycle restoring division, then applies RISC-V sign fix-up and special-case results.
- Returns the result on a valid/ready handshake.
- Sits in the execute stage beside the ALU/multiplier; the pipeline stalls while o_div_ctrl_busy is high.

---
 rtl/riscv_core_div_pkg.sv | 29 ++
 rtl/riscv_core_div_in.sv | 44 ++++
 rtl/riscv_core_div_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/riscv_core_div_pkg.sv
// ============================================================================
// Module      : riscv_core_div_pkg
// Description : Shared types and constants for the M-extension divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_core_div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIXUP  = 2'd2,
        DONE   = 2'd3
    } div_state_e;

    // Bit 0 clear means signed; bit 1 set selects the remainder
    localparam logic [1:0] DIV  = 2'b00;
    localparam logic [1:0] DIVU = 2'b01;
    localparam logic [1:0] REM  = 2'b10;
    localparam logic [1:0] REMU = 2'b11;

    function automatic logic [127:0] most_neg(input int unsigned width);
        most_neg = 128'd1 << (width - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_core_div_in.sv
// ============================================================================
// Module      : riscv_core_div_in
// Description : Operand conditioning: sign extraction, width truncation, magnitudes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_core_div_in
    import riscv_core_div_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] i_src_a,
    input  logic [XLEN-1:0] i_src_b,
    input  logic            i_is_signed,
    input  logic            i_isword,
    output logic            o_sign_a,
    output logic            o_sign_b,
    output logic [XLEN-1:0] o_trunc_a,
    output logic [XLEN-1:0] o_trunc_b,
    output logic [XLEN-1:0] o_mag_a,
    output logic [XLEN-1:0] o_mag_b
);

    localparam int HALF = XLEN / 2;

    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;

    always_comb begin
        o_sign_a  = i_isword ? i_src_a[HALF-1] : i_src_a[XLEN-1];
        o_sign_b  = i_isword ? i_src_b[HALF-1] : i_src_b[XLEN-1];
        o_trunc_a = i_isword ? {{HALF{1'b0}}, i_src_a[HALF-1:0]} : i_src_a;
        o_trunc_b = i_isword ? {{HALF{1'b0}}, i_src_b[HALF-1:0]} : i_src_b;
        // Negating at full width and truncating yields the correct half-width magnitude
        w_abs_a   = (i_is_signed && o_sign_a) ? (~i_src_a + 1'b1) : i_src_a;
        w_abs_b   = (i_is_signed && o_sign_b) ? (~i_src_b + 1'b1) : i_src_b;
        o_mag_a   = i_isword ? {{HALF{1'b0}}, w_abs_a[HALF-1:0]} : w_abs_a;
        o_mag_b   = i_isword ? {{HALF{1'b0}}, w_abs_b[HALF-1:0]} : w_abs_b;
    end

endmodule

`default_nettype wire

// File: rtl/riscv_core_div_ctrl.sv
// ============================================================================
// Module      : riscv_core_div_ctrl
// Description : Sequencer for restoring integer division with RISC-V fix-up.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_core_div_ctrl
    import riscv_core_div_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_div_ctrl_valid,
    output logic            o_div_ctrl_ready,
    input  logic [XLEN-1:0] i_div_ctrl_srcA,
    input  logic [XLEN-1:0] i_div_ctrl_srcB,
    input  logic [1:0]      i_div_ctrl_control,
    input  logic            i_div_ctrl_isword,
    input  logic            i_div_ctrl_flush,
    output logic            o_div_ctrl_busy,
    output logic            o_div_ctrl_valid,
    input  logic            i_div_ctrl_res_ready,
    output logic [XLEN-1:0] o_div_ctrl_result
);

    localparam int HALF = XLEN / 2;
    localparam int CW   = $clog2(XLEN);

    localparam logic [127:0]    c_NEG_D_WIDE = most_neg(XLEN);
    localparam logic [127:0]    c_NEG_W_WIDE = most_neg(HALF);
    localparam logic [XLEN-1:0] c_NEG_D      = c_NEG_D_WIDE[XLEN-1:0];
    localparam logic [XLEN-1:0] c_NEG_W      = c_NEG_W_WIDE[XLEN-1:0];
    localparam logic [XLEN-1:0] c_ONES_D     = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] c_ONES_W     = {{HALF{1'b0}}, {HALF{1'b1}}};
    localparam logic [CW-1:0]   c_CNT_D      = CW'(XLEN - 1);
    localparam logic [CW-1:0]   c_CNT_W      = CW'(HALF - 1);

    function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
        sext_word = {{HALF{v[HALF-1]}}, v[HALF-1:0]};
    endfunction

    div_state_e      state_q,  state_d;
    logic [1:0]      op_q,     op_d;
    logic            isword_q, isword_d;
    logic            sign_a_q, sign_a_d;
    logic            sign_b_q, sign_b_d;
    logic [XLEN-1:0] dvd_q,    dvd_d;
    logic [XLEN-1:0] dvs_q,    dvs_d;
    logic [XLEN-1:0] rem_q,    rem_d;
    logic [XLEN-1:0] quo_q,    quo_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic            valid_q,  valid_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            w_is_signed;
    logic            w_sign_a, w_sign_b;
    logic [XLEN-1:0] w_trunc_a, w_trunc_b, w_mag_a, w_mag_b;

    assign w_is_signed = ~i_div_ctrl_control[0];

    riscv_core_div_in #(.XLEN(XLEN)) u_div_in (
        .i_src_a     (i_div_ctrl_srcA),
        .i_src_b     (i_div_ctrl_srcB),
        .i_is_signed (w_is_signed),
        .i_isword    (i_div_ctrl_isword),
        .o_sign_a    (w_sign_a),
        .o_sign_b    (w_sign_b),
        .o_trunc_a   (w_trunc_a),
        .o_trunc_b   (w_trunc_b),
        .o_mag_a     (w_mag_a),
        .o_mag_b     (w_mag_b)
    );

    logic            w_div_zero, w_overflow;
    logic [XLEN-1:0] w_sp_quo, w_sp_rem, w_sp_sel, w_sp_res;
    logic [XLEN:0]   w_rem_shift;
    logic [XLEN-1:0] w_rem_sub;
    logic            w_ge;
    logic            w_signed_q;
    logic [XLEN-1:0] w_quo_fix, w_rem_fix, w_fix_sel, w_fix_res;

    always_comb begin
        w_div_zero  = (w_trunc_b == '0);
        w_overflow  = w_is_signed
                    && (w_trunc_a == (i_div_ctrl_isword ? c_NEG_W : c_NEG_D))
                    && (w_trunc_b == (i_div_ctrl_isword ? c_ONES_W : c_ONES_D));
        w_sp_quo    = w_div_zero ? c_ONES_D : (i_div_ctrl_isword ? c_NEG_W : c_NEG_D);
        w_sp_rem    = w_div_zero ? w_trunc_a : '0;
        w_sp_sel    = i_div_ctrl_control[1] ? w_sp_rem : w_sp_quo;
        w_sp_res    = i_div_ctrl_isword ? sext_word(w_sp_sel) : w_sp_sel;

        w_rem_shift = {rem_q, dvd_q[XLEN-1]};
        w_ge        = (w_rem_shift >= {1'b0, dvs_q});
        // When the compare passes the difference fits in XLEN bits
        w_rem_sub   = w_rem_shift[XLEN-1:0] - dvs_q;

        w_signed_q  = ~op_q[0];
        w_quo_fix   = (w_signed_q && (sign_a_q ^ sign_b_q)) ? (~quo_q + 1'b1) : quo_q;
        w_rem_fix   = (w_signed_q && sign_a_q) ? (~rem_q + 1'b1) : rem_q;
        w_fix_sel   = op_q[1] ? w_rem_fix : w_quo_fix;
        w_fix_res   = isword_q ? sext_word(w_fix_sel) : w_fix_sel;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        isword_d = isword_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (i_div_ctrl_valid) begin
                    op_d     = i_div_ctrl_control;
                    isword_d = i_div_ctrl_isword;
                    sign_a_d = w_sign_a;
                    sign_b_d = w_sign_b;
                    // Word dividends sit in the upper half so the MSB-first loop serves both widths
                    dvd_d    = i_div_ctrl_isword ? (w_mag_a << HALF) : w_mag_a;
                    dvs_d    = w_mag_b;
                    rem_d    = '0;
                    quo_d    = '0;
                    if (w_div_zero || w_overflow) begin
                        result_d = w_sp_res;
                        valid_d  = 1'b1;
                        state_d  = DONE;
                    end else begin
                        cnt_d   = i_div_ctrl_isword ? c_CNT_W : c_CNT_D;
                        state_d = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                dvd_d = {dvd_q[XLEN-2:0], 1'b0};
                rem_d = w_ge ? w_rem_sub : w_rem_shift[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], w_ge};
                if (cnt_q == '0) begin
                    state_d = FIXUP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIXUP: begin
                result_d = w_fix_res;
                valid_d  = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                if (i_div_ctrl_res_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (i_div_ctrl_flush) begin
            state_d = IDLE;
            valid_d = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            op_q     <= DIV;
            isword_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            isword_q <= isword_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    assign o_div_ctrl_ready  = (state_q == IDLE);
    assign o_div_ctrl_busy   = (state_q != IDLE);
    assign o_div_ctrl_valid  = valid_q;
    assign o_div_ctrl_result = result_q;

endmodule

`default_nettype wire
